// File: rtl/dec_comm_regs_if.sv
// Command-FIFO read side and response-FIFO write side of dec_comm_regs.
// master = the decoder, slave = the FIFO pair.
interface dec_comm_regs_if;
  logic        cmd_fifo_empty;
  logic [31:0] cmd_fifo_data;
  logic        cmd_fifo_read;
  logic        rsp_fifo_full;
  logic [31:0] rsp_fifo_data;
  logic        rsp_fifo_write;

  modport master (
    input  cmd_fifo_empty, cmd_fifo_data, rsp_fifo_full,
    output cmd_fifo_read, rsp_fifo_data, rsp_fifo_write
  );

  modport slave (
    output cmd_fifo_empty, cmd_fifo_data, rsp_fifo_full,
    input  cmd_fifo_read, rsp_fifo_data, rsp_fifo_write
  );
endinterface

// File: rtl/dec_comm_regs.sv
// Command decoder: parses 1/2-word commands, drives RW registers, returns status and responses.
// Optional payload-wait timeout enabled by defining DEC_PAYLOAD_TIMEOUT_EN.
module dec_comm_regs #(
  parameter int unsigned NREGS       = 4,
  parameter int unsigned NSTAT       = 4,
  parameter logic [31:0] VERSION     = 32'h302E_320A,
  parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  dec_comm_regs_if.master                       fifo,
  output logic [32*NREGS-1:0]                   reg_out,
  input  logic [32*((NSTAT > 0) ? NSTAT : 1)-1:0] stat_in,
  output logic                                  led_driver,
  output logic                                  busy
);

  localparam logic [31:0] ACK     = 32'h4143_4B0A;
  localparam logic [31:0] NAK     = 32'h4E41_4B0A;
  localparam logic [31:0] LEG_ON  = 32'hABAB_ABAB;
  localparam logic [31:0] LEG_OFF = 32'hEEEE_AAAA;
  localparam logic [31:0] LEG_VER = 32'hCCCC_CCCC;
  localparam logic [7:0]  OP_WRITE   = 8'h01;
  localparam logic [7:0]  OP_READ    = 8'h02;
  localparam logic [7:0]  OP_VERSION = 8'h03;
  localparam logic [7:0]  OP_CLEAR   = 8'h04;

  typedef enum logic [3:0] {
    IDLE, HDR_RD, HDR_WAIT, HDR_CAP, PAY_WAIT, PAY_RD, PAY_WAIT2, PAY_CAP, EXEC, RSP0, RSP1
  } state_t;

  state_t                 state;
  logic [NREGS-1:0][31:0] regs;
  logic [31:0]            hdr;
  logic [31:0]            pay;
  logic [31:0]            rsp_w1;
  logic                   rsp_two;
  logic                   tmo;

  logic [31:0] addr_w;
  logic [7:0]  opcode;
  logic [31:0] rd_word;
  logic [31:0] ex_w0;
  logic [31:0] ex_w1;
  logic        ex_two;
  logic        ex_wr;
  logic        ex_clr;
  logic        ex_led_set;
  logic        ex_led_clr;

`ifdef DEC_PAYLOAD_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] tmo_cnt;
`else
  // Timeout length has no effect without the counter.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYC;
  assign tmo = 1'b0;
`endif

  assign opcode     = hdr[31:24];
  assign addr_w     = {16'h0000, hdr[15:0]};
  assign reg_out    = regs;
  assign led_driver = regs[0][0];
  assign busy       = (state != IDLE);

  always_comb begin
    rd_word = '0;
    for (int unsigned k = 0; k < NREGS; k++)
      if (addr_w == k) rd_word = regs[k];
    for (int unsigned k = 0; k < NSTAT; k++)
      if (addr_w == NREGS + k) rd_word = stat_in[32*k +: 32];
  end

  // Legacy full-word commands take priority over opcode decoding.
  always_comb begin
    ex_w0      = NAK;
    ex_w1      = '0;
    ex_two     = 1'b0;
    ex_wr      = 1'b0;
    ex_clr     = 1'b0;
    ex_led_set = 1'b0;
    ex_led_clr = 1'b0;
    if (tmo) begin
      ex_w0 = NAK;
    end else if (hdr == LEG_ON) begin
      ex_led_set = 1'b1;
      ex_w0      = ACK;
    end else if (hdr == LEG_OFF) begin
      ex_led_clr = 1'b1;
      ex_w0      = ACK;
    end else if (hdr == LEG_VER) begin
      ex_w0 = VERSION;
    end else begin
      case (opcode)
        OP_WRITE: begin
          if (addr_w < NREGS) begin
            ex_wr = 1'b1;
            ex_w0 = ACK;
          end
        end
        OP_READ: begin
          if (addr_w < NREGS + NSTAT) begin
            ex_w0  = ACK;
            ex_w1  = rd_word;
            ex_two = 1'b1;
          end
        end
        OP_VERSION: ex_w0 = VERSION;
        OP_CLEAR: begin
          ex_clr = 1'b1;
          ex_w0  = ACK;
        end
        default: ex_w0 = NAK;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state               <= IDLE;
      fifo.cmd_fifo_read  <= 1'b0;
      fifo.rsp_fifo_write <= 1'b0;
      fifo.rsp_fifo_data  <= '0;
      regs                <= '0;
      hdr                 <= '0;
      pay                 <= '0;
      rsp_w1              <= '0;
      rsp_two             <= 1'b0;
`ifdef DEC_PAYLOAD_TIMEOUT_EN
      tmo_cnt             <= '0;
      tmo                 <= 1'b0;
`endif
    end else begin
      fifo.cmd_fifo_read  <= 1'b0;
      fifo.rsp_fifo_write <= 1'b0;
      case (state)
        IDLE: begin
          if (!fifo.cmd_fifo_empty) begin
            fifo.cmd_fifo_read <= 1'b1;
            state              <= HDR_RD;
          end
        end
        HDR_RD:   state <= HDR_WAIT;
        HDR_WAIT: state <= HDR_CAP;
        HDR_CAP: begin
          hdr <= fifo.cmd_fifo_data;
`ifdef DEC_PAYLOAD_TIMEOUT_EN
          tmo     <= 1'b0;
          tmo_cnt <= '0;
`endif
          state <= (fifo.cmd_fifo_data[31:24] == OP_WRITE) ? PAY_WAIT : EXEC;
        end
        PAY_WAIT: begin
          if (!fifo.cmd_fifo_empty) begin
            fifo.cmd_fifo_read <= 1'b1;
            state              <= PAY_RD;
          end
`ifdef DEC_PAYLOAD_TIMEOUT_EN
          else begin
            tmo_cnt <= tmo_cnt + CW'(1);
            if (tmo_cnt == CW'(TIMEOUT_CYC - 1)) begin
              tmo   <= 1'b1;
              state <= EXEC;
            end
          end
`endif
        end
        PAY_RD:    state <= PAY_WAIT2;
        PAY_WAIT2: state <= PAY_CAP;
        PAY_CAP: begin
          pay   <= fifo.cmd_fifo_data;
          state <= EXEC;
        end
        // Register effects land on the same edge that raises the first response write.
        EXEC: begin
          fifo.rsp_fifo_data  <= ex_w0;
          fifo.rsp_fifo_write <= !fifo.rsp_fifo_full;
          rsp_w1              <= ex_w1;
          rsp_two             <= ex_two;
          state               <= RSP0;
          if (ex_clr) begin
            regs <= '0;
          end else if (ex_wr) begin
            for (int unsigned k = 0; k < NREGS; k++)
              if (addr_w == k) regs[k] <= pay;
          end else if (ex_led_set) begin
            regs[0][0] <= 1'b1;
          end else if (ex_led_clr) begin
            regs[0][0] <= 1'b0;
          end
        end
        // A raised write strobe means the current word is taken at this edge.
        RSP0: begin
          if (fifo.rsp_fifo_write) begin
            if (rsp_two) begin
              fifo.rsp_fifo_data  <= rsp_w1;
              fifo.rsp_fifo_write <= !fifo.rsp_fifo_full;
              state               <= RSP1;
            end else begin
              state <= IDLE;
            end
          end else begin
            fifo.rsp_fifo_write <= !fifo.rsp_fifo_full;
          end
        end
        RSP1: begin
          if (fifo.rsp_fifo_write) state <= IDLE;
          else fifo.rsp_fifo_write <= !fifo.rsp_fifo_full;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dec_comm_regs.sv
// Self-checking bench for dec_comm_regs: FIFO models, response monitor and a command-level reference model.
module tb_dec_comm_regs;
  localparam int unsigned NREGS = 4;
  localparam int unsigned NSTAT = 4;
  localparam int unsigned TO    = 16;
  localparam logic [31:0] ACK = 32'h4143_4B0A;
  localparam logic [31:0] NAK = 32'h4E41_4B0A;
  localparam logic [31:0] VER = 32'h302E_320A;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [32*NREGS-1:0] reg_out;
  logic [32*NSTAT-1:0] stat_in = '0;
  logic led_driver;
  logic busy;

  dec_comm_regs_if fif ();

  dec_comm_regs #(.NREGS(NREGS), .NSTAT(NSTAT), .VERSION(VER), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset_n(reset_n), .fifo(fif), .reg_out(reg_out),
    .stat_in(stat_in), .led_driver(led_driver), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int unsigned cyc = 0;
  int n_rd = 0;
  logic [31:0] cq[$];
  logic [31:0] rsp_q[$];
  logic [31:0] exp_q[$];
  int unsigned rd_cyc_q[$];
  int unsigned wr_cyc_q[$];
  logic [32*NREGS-1:0] wr_reg_q[$];
  logic [31:0] dout = '0;
  logic [31:0] m_regs[NREGS];
  logic [31:0] m_stat[NSTAT];

  // Command FIFO (non-show-ahead + one register stage) and response FIFO recorder.
  always @(posedge clk) begin
    cyc++;
    if (fif.cmd_fifo_read) begin
      n_rd++;
      rd_cyc_q.push_back(cyc);
      if (cq.size() > 0) dout <= cq.pop_front();
    end
    fif.cmd_fifo_data  <= dout;
    fif.cmd_fifo_empty <= (cq.size() == 0);
    if (fif.rsp_fifo_write) begin
      rsp_q.push_back(fif.rsp_fifo_data);
      wr_cyc_q.push_back(cyc);
      wr_reg_q.push_back(reg_out);
    end
  end

  function automatic void model(input logic [31:0] h, input logic [31:0] p);
    int unsigned a;
    a = int'(h[15:0]);
    exp_q.delete();
    if (h == 32'hABAB_ABAB) begin
      m_regs[0][0] = 1'b1;
      exp_q.push_back(ACK);
    end else if (h == 32'hEEEE_AAAA) begin
      m_regs[0][0] = 1'b0;
      exp_q.push_back(ACK);
    end else if (h == 32'hCCCC_CCCC) begin
      exp_q.push_back(VER);
    end else begin
      case (h[31:24])
        8'h01: if (a < NREGS) begin m_regs[a] = p; exp_q.push_back(ACK); end
               else exp_q.push_back(NAK);
        8'h02: if (a < NREGS) begin exp_q.push_back(ACK); exp_q.push_back(m_regs[a]); end
               else if (a < NREGS + NSTAT) begin exp_q.push_back(ACK); exp_q.push_back(m_stat[a-NREGS]); end
               else exp_q.push_back(NAK);
        8'h03: exp_q.push_back(VER);
        8'h04: begin for (int k = 0; k < NREGS; k++) m_regs[k] = '0; exp_q.push_back(ACK); end
        default: exp_q.push_back(NAK);
      endcase
    end
  endfunction

  function automatic logic [32*NREGS-1:0] exp_regs();
    logic [32*NREGS-1:0] r;
    for (int k = 0; k < NREGS; k++) r[32*k +: 32] = m_regs[k];
    return r;
  endfunction

  function automatic bit rsp_matches();
    if (rsp_q.size() != exp_q.size()) return 1'b0;
    for (int i = 0; i < rsp_q.size(); i++) if (rsp_q[i] !== exp_q[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic set_stat(input int k, input logic [31:0] v);
    m_stat[k] = v;
    stat_in[32*k +: 32] = v;
  endtask

  task automatic push_cmd(input logic [31:0] h, input logic [31:0] p, input bit two);
    rsp_q.delete(); wr_cyc_q.delete(); rd_cyc_q.delete(); wr_reg_q.delete();
    n_rd = 0;
    cq.push_back(h);
    if (two) cq.push_back(p);
  endtask

  task automatic wait_done(input bit rnd_full, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (rnd_full) fif.rsp_fifo_full = ($urandom_range(0, 2) == 0);
      if (cq.size() == 0 && !busy && rsp_q.size() > 0) begin ok = 1'b1; break; end
    end
    fif.rsp_fifo_full = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic exec_cmd(input logic [31:0] h, input logic [31:0] p, input bit two,
                          input bit rnd_full, output bit ok);
    model(h, p);
    push_cmd(h, p, two);
    wait_done(rnd_full, ok);
  endtask

  task automatic test_reset();
    fif.rsp_fifo_full = 1'b0;
    for (int k = 0; k < NREGS; k++) m_regs[k] = '0;
    for (int k = 0; k < NSTAT; k++) set_stat(k, '0);
    repeat (3) @(negedge clk);
    total++; if (fif.cmd_fifo_read !== 1'b0) begin bad++; $display("FAIL reset_read got=%b exp=0", fif.cmd_fifo_read); end
    total++; if (fif.rsp_fifo_write !== 1'b0) begin bad++; $display("FAIL reset_write got=%b exp=0", fif.rsp_fifo_write); end
    total++; if (fif.rsp_fifo_data !== 32'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", fif.rsp_fifo_data); end
    total++; if (reg_out !== '0) begin bad++; $display("FAIL reset_regs got=%h exp=0", reg_out); end
    total++; if (led_driver !== 1'b0) begin bad++; $display("FAIL reset_led got=%b exp=0", led_driver); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_legacy();
    bit ok;
    exec_cmd(32'hABAB_ABAB, '0, 1'b0, 1'b0, ok);
    total++; if (!ok || !rsp_matches()) begin bad++; $display("FAIL led_on_rsp got=%0d words %h exp=1 word %h", rsp_q.size(), rsp_q[0], ACK); end
    total++; if (wr_reg_q[0][0] !== 1'b1 || led_driver !== 1'b1) begin bad++; $display("FAIL led_on_val got=%b exp=1", led_driver); end
    total++; if (wr_cyc_q[0] - rd_cyc_q[0] != 4) begin bad++; $display("FAIL led_on_latency got=%0d exp=4", wr_cyc_q[0] - rd_cyc_q[0]); end
    total++; if (n_rd != 1) begin bad++; $display("FAIL led_on_reads got=%0d exp=1", n_rd); end
    exec_cmd(32'hEEEE_AAAA, '0, 1'b0, 1'b0, ok);
    total++; if (!ok || !rsp_matches()) begin bad++; $display("FAIL led_off_rsp got=%0d words %h exp=1 word %h", rsp_q.size(), rsp_q[0], ACK); end
    total++; if (led_driver !== 1'b0 || reg_out !== exp_regs()) begin bad++; $display("FAIL led_off_val got=%h exp=%h", reg_out, exp_regs()); end
  endtask

  task automatic test_write_read();
    bit ok;
    exec_cmd(32'h0100_0002, 32'hDEAD_BEEF, 1'b1, 1'b0, ok);
    total++; if (!ok || !rsp_matches()) begin bad++; $display("FAIL write_rsp got=%0d words %h exp=%h", rsp_q.size(), rsp_q[0], ACK); end
    total++; if (reg_out[95:64] !== 32'hDEAD_BEEF) begin bad++; $display("FAIL write_reg2 got=%h exp=deadbeef", reg_out[95:64]); end
    total++; if (wr_reg_q[0] !== exp_regs()) begin bad++; $display("FAIL write_visible_at_ack got=%h exp=%h", wr_reg_q[0], exp_regs()); end
    total++; if (n_rd != 2) begin bad++; $display("FAIL write_reads got=%0d exp=2", n_rd); end
    exec_cmd(32'h0200_0002, '0, 1'b0, 1'b0, ok);
    total++; if (!ok || !rsp_matches()) begin bad++; $display("FAIL read_rsp got=%0d words %h %h exp=%h %h", rsp_q.size(), rsp_q[0], rsp_q[1], exp_q[0], exp_q[1]); end
    total++; if (wr_cyc_q[0] - rd_cyc_q[0] != 4 || wr_cyc_q[1] - wr_cyc_q[0] != 1) begin bad++; $display("FAIL read_timing got=%0d,%0d exp=4,1", wr_cyc_q[0] - rd_cyc_q[0], wr_cyc_q[1] - wr_cyc_q[0]); end
  endtask

  task automatic test_status();
    bit ok;
    set_stat(0, 32'h1234_5678);
    set_stat(3, 32'hCAFE_0003);
    exec_cmd(32'h0200_0004, '0, 1'b0, 1'b0, ok);
    total++; if (!ok || !rsp_matches()) begin bad++; $display("FAIL stat0_rsp got=%0d words %h %h exp=%h %h", rsp_q.size(), rsp_q[0], rsp_q[1], exp_q[0], exp_q[1]); end
    exec_cmd(32'h02FF_0007, '0, 1'b0, 1'b0, ok);
    total++; if (!ok || !rsp_matches()) begin bad++; $display("FAIL stat3_rsp got=%0d words %h %h exp=%h %h", rsp_q.size(), rsp_q[0], rsp_q[1], exp_q[0], exp_q[1]); end
    exec_cmd(32'h0100_0004, 32'h5555_AAAA, 1'b1, 1'b0, ok);
    total++; if (!ok || !rsp_matches()) begin bad++; $display("FAIL ro_write_rsp got=%0d words %h exp=%h", rsp_q.size(), rsp_q[0], NAK); end
    total++; if (reg_out !== exp_regs() || n_rd != 2) begin bad++; $display("FAIL ro_write_state got=%h reads=%0d exp=%h reads=2", reg_out, n_rd, exp_regs()); end
    exec_cmd(32'h0200_0008, '0, 1'b0, 1'b0, ok);
    total++; if (!ok || !rsp_matches()) begin bad++; $display("FAIL bad_addr_read got=%0d words %h exp=%h", rsp_q.size(), rsp_q[0], NAK); end
  endtask

  task automatic test_opcodes();
    bit ok;
    exec_cmd(32'h7700_0000, '0, 1'b0, 1'b0, ok);
    total++; if (!ok || !rsp_matches() || n_rd != 1) begin bad++; $display("FAIL unknown_op got=%0d words %h reads=%0d exp=%h reads=1", rsp_q.size(), rsp_q[0], n_rd, NAK); end
    exec_cmd(32'h0300_0000, '0, 1'b0, 1'b0, ok);
    total++; if (!ok || !rsp_matches()) begin bad++; $display("FAIL version got=%0d words %h exp=%h", rsp_q.size(), rsp_q[0], VER); end
    exec_cmd(32'hCCCC_CCCC, '0, 1'b0, 1'b0, ok);
    total++; if (!ok || !rsp_matches()) begin bad++; $display("FAIL legacy_version got=%0d words %h exp=%h", rsp_q.size(), rsp_q[0], VER); end
    exec_cmd(32'h0100_0001, 32'h0BAD_F00D, 1'b1, 1'b0, ok);
    exec_cmd(32'h0400_0000, '0, 1'b0, 1'b0, ok);
    total++; if (!ok || !rsp_matches() || reg_out !== '0) begin bad++; $display("FAIL clear got=%h rsp=%h exp=0 rsp=%h", reg_out, rsp_q[0], ACK); end
  endtask

  task automatic test_backpressure();
    bit ok;
    exec_cmd(32'h0100_0003, 32'h0F0F_1234, 1'b1, 1'b0, ok);
    @(negedge clk);
    fif.rsp_fifo_full = 1'b1;
    model(32'h0200_0003, '0);
    push_cmd(32'h0200_0003, '0, 1'b0);
    repeat (16) @(negedge clk);
    total++; if (rsp_q.size() != 0) begin bad++; $display("FAIL hold_no_write got=%0d words exp=0", rsp_q.size()); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL hold_busy got=%b exp=1", busy); end
    fif.rsp_fifo_full = 1'b0;
    wait_done(1'b0, ok);
    total++; if (!ok || !rsp_matches()) begin bad++; $display("FAIL release_rsp got=%0d words %h %h exp=%h %h", rsp_q.size(), rsp_q[0], rsp_q[1], exp_q[0], exp_q[1]); end
    total++; if (wr_cyc_q[1] - wr_cyc_q[0] != 1) begin bad++; $display("FAIL release_consecutive got=%0d exp=1", wr_cyc_q[1] - wr_cyc_q[0]); end
  endtask

  task automatic test_random();
    bit ok;
    logic [31:0] h;
    logic [31:0] p;
    logic [7:0] op;
    int sel;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0) set_stat($urandom_range(0, NSTAT-1), $urandom);
      sel = $urandom_range(0, 11);
      case (sel)
        0: op = 8'h03;
        1: op = 8'h04;
        2: op = 8'($urandom_range(5, 255));
        3, 4, 5, 6: op = 8'h01;
        default: op = 8'h02;
      endcase
      h = {op, 8'($urandom), 16'($urandom_range(0, 9))};
      if (sel == 11) h = 32'hABAB_ABAB;
      if (sel == 10) h = 32'hEEEE_AAAA;
      p = $urandom;
      exec_cmd(h, p, (h[31:24] == 8'h01), 1'b1, ok);
      total++; if (!ok || !rsp_matches()) begin bad++; $display("FAIL rand_rsp cmd=%h got=%0d words %h %h exp=%0d words %h %h", h, rsp_q.size(), rsp_q[0], rsp_q[1], exp_q.size(), exp_q[0], exp_q[1]); end
      total++; if (reg_out !== exp_regs()) begin bad++; $display("FAIL rand_regs cmd=%h got=%h exp=%h", h, reg_out, exp_regs()); end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    exec_cmd(32'h0100_0001, 32'h8765_4321, 1'b1, 1'b0, ok);
    exec_cmd(32'hABAB_ABAB, '0, 1'b0, 1'b0, ok);
    push_cmd(32'h0100_0003, '0, 1'b0);
    repeat (10) @(negedge clk);
    total++; if (busy !== 1'b1 || reg_out === '0) begin bad++; $display("FAIL pre_reset_state busy=%b regs=%h exp busy=1 regs nonzero", busy, reg_out); end
    reset_n = 1'b0;
    #1;
    total++; if ({fif.cmd_fifo_read, fif.rsp_fifo_write, led_driver, busy} !== 4'b0) begin bad++; $display("FAIL midreset_ctrl got=%b exp=0000", {fif.cmd_fifo_read, fif.rsp_fifo_write, led_driver, busy}); end
    total++; if (reg_out !== '0 || fif.rsp_fifo_data !== 32'h0) begin bad++; $display("FAIL midreset_data got=%h/%h exp=0/0", reg_out, fif.rsp_fifo_data); end
    for (int k = 0; k < NREGS; k++) m_regs[k] = '0;
    repeat (2) @(negedge clk);
    cq.delete();
    reset_n = 1'b1;
    repeat (8) @(negedge clk);
    total++; if (rsp_q.size() != 0 || busy !== 1'b0) begin bad++; $display("FAIL midreset_no_rsp got=%0d words busy=%b exp=0 words busy=0", rsp_q.size(), busy); end
    exec_cmd(32'h0200_0001, '0, 1'b0, 1'b0, ok);
    total++; if (!ok || !rsp_matches()) begin bad++; $display("FAIL post_reset_read got=%0d words %h %h exp=%h %h", rsp_q.size(), rsp_q[0], rsp_q[1], exp_q[0], exp_q[1]); end
  endtask

`ifdef DEC_PAYLOAD_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    exec_cmd(32'h0100_0002, 32'h1111_2222, 1'b1, 1'b0, ok);
    push_cmd(32'h0100_0001, '0, 1'b0);
    exp_q.delete();
    exp_q.push_back(NAK);
    wait_done(1'b0, ok);
    total++; if (!ok || !rsp_matches()) begin bad++; $display("FAIL timeout_rsp got=%0d words %h exp=%h", rsp_q.size(), rsp_q[0], NAK); end
    total++; if (reg_out !== exp_regs()) begin bad++; $display("FAIL timeout_regs got=%h exp=%h", reg_out, exp_regs()); end
    total++; if (wr_cyc_q[0] - rd_cyc_q[0] < 19 || wr_cyc_q[0] - rd_cyc_q[0] > 21) begin bad++; $display("FAIL timeout_delay got=%0d exp=20", wr_cyc_q[0] - rd_cyc_q[0]); end
    exec_cmd(32'h0200_0002, '0, 1'b0, 1'b0, ok);
    total++; if (!ok || !rsp_matches()) begin bad++; $display("FAIL after_timeout_read got=%0d words %h %h exp=%h %h", rsp_q.size(), rsp_q[0], rsp_q[1], exp_q[0], exp_q[1]); end
  endtask
`endif

  initial begin
    test_reset();
    test_legacy();
    test_write_read();
    test_status();
    test_opcodes();
    test_backpressure();
    test_random();
`ifdef DEC_PAYLOAD_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dec_comm_regs.md
# dec_comm_regs

Parametrised command decoder between the HPS-to-FPGA command FIFO and the FPGA-to-HPS response FIFO. Parses one-word and two-word commands, drives a bank of read/write control registers, reads back read-only status words, and queues one- or two-word responses while honouring response-FIFO backpressure. It is the next-generation command front end, replacing the fixed single-word LED/version decoder while keeping its legacy command words.

## Interface
- NREGS, 4: number of 32-bit RW control registers (1..256).
- NSTAT, 4: number of 32-bit RO status words (0..256).
- VERSION, 32'h302E_320A: word returned by the version command ("0.2\n").
- TIMEOUT_CYC, 1_000_000: payload-wait timeout in clk cycles (≥2).
- clk  in  1  system clock; all logic on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cmd_fifo_empty  in  1  command FIFO empty flag.
- cmd_fifo_data  in  32  command FIFO read data.
- cmd_fifo_read  out  1  command FIFO read strobe, one-cycle pulse per word.
- rsp_fifo_full  in  1  response FIFO full flag.
- rsp_fifo_data  out  32  response word.
- rsp_fifo_write  out  1  response FIFO write strobe, one-cycle pulse per word.
- reg_out  out  32*NREGS  RW registers; register k at bits [32k+31:32k].
- stat_in  in  32*max(NSTAT,1)  RO status words, same packing.
- led_driver  out  1  equals reg_out[0].
- busy  out  1  high whenever the FSM is not in IDLE.

## Operation
- Header word: opcode = [31:24], address = [15:0]; bits [23:16] ignored.
- Opcodes: 0x01 WRITE (header + one payload word), 0x02 READ, 0x03 VERSION, 0x04 CLEAR (all RW registers to 0).
- Legacy full-word commands are checked before the opcode: 32'hABAB_ABAB sets reg_out[0]; 32'hEEEE_AAAA clears reg_out[0]; 32'hCCCC_CCCC behaves as VERSION.
- Address map: 0..NREGS-1 RW; NREGS..NREGS+NSTAT-1 RO status; otherwise invalid.
- Responses are ACK = 32'h41434B0A, NAK = 32'h4E414B0A. VERSION returns the VERSION word only. A valid READ returns ACK followed by the data word.
- WRITE to an RO or invalid address: the payload is still consumed, then NAK is returned and no register changes. READ of an invalid address returns NAK. An unknown opcode returns NAK and consumes no payload.
- FSM states: IDLE → HDR_RD (read pulse) → HDR_WAIT → HDR_CAP → EXEC, or → PAY_WAIT → PAY_RD → PAY_WAIT2 → PAY_CAP → EXEC; then EXEC → RSP0 → (RSP1) → IDLE.
- Responses are never dropped. A write is issued only in a cycle where rsp_fifo_full=0; otherwise the FSM holds in RSP0/RSP1 with rsp_fifo_write=0.
- No new command is fetched until its response is fully written.

## Timing
- FIFO read latency: data sampled 2 cycles after the cmd_fifo_read pulse, i.e. non-show-ahead FIFO plus one registered stage.
- Single-word command: IDLE sees empty=0 at edge N; read=1 in cycle N+1; capture at N+3; EXEC at N+4; response write in cycle N+5 if not full.
- WRITE: the register update becomes visible in the same cycle rsp_fifo_write is asserted for the ACK.
- READ: ACK in cycle N+5 and data in cycle N+6 with no backpressure. stat_in is sampled in EXEC.
- Reset values: cmd_fifo_read=0, rsp_fifo_write=0, rsp_fifo_data=0, reg_out=0, led_driver=0, busy=0, FSM=IDLE, timeout counter=0.
- Reset asserted mid-command: everything returns to reset values immediately. A partially consumed command is discarded with no response.
- Back-to-back commands: the next header read pulse occurs no earlier than 1 cycle after the final response write.

## Configuration
- DEC_PAYLOAD_TIMEOUT_EN defined: in PAY_WAIT the counter increments each cycle while cmd_fifo_empty=1. When the count reaches TIMEOUT_CYC, the FSM sends NAK, changes no register and returns to IDLE. The counter clears on entry to PAY_WAIT.
- DEC_PAYLOAD_TIMEOUT_EN undefined: PAY_WAIT waits indefinitely. No counter is synthesised.

## Test plan
- Push 32'hABAB_ABAB → led_driver=1 at cycle N+5 with ACK 32'h41434B0A written once; then push 32'hEEEE_AAAA → led_driver=0 with ACK.
- Push 32'h0100_0002 then 32'hDEAD_BEEF (NREGS=4) → reg_out[95:64]=32'hDEADBEEF with ACK. Then push READ 32'h0200_0002 → ACK followed by 32'hDEADBEEF.
- stat_in word 0 = 32'h1234_5678, push READ 32'h0200_0004 → ACK followed by 32'h12345678. Push WRITE to 0x0004 with any payload → payload consumed, NAK, no register change.
- Push 32'h7700_0000 → NAK only, a single cmd_fifo_read pulse; push 32'h0300_0000 → 32'h302E320A.
- Hold rsp_fifo_full=1 during a READ for 10 cycles → rsp_fifo_write stays 0 and busy=1. Release → ACK and data written on consecutive non-full cycles, none lost.
- With DEC_PAYLOAD_TIMEOUT_EN and TIMEOUT_CYC=16: push WRITE header only → NAK after 16 empty cycles, registers unchanged. Assert reset_n=0 mid-payload-wait → all outputs 0, no response.
